// File: rtl/ov_camera_emulator.sv
// OV7670 pixel-port stand-in: pclk = clk_25/2 plus v_sync, h_ref and RGB565 bytes from a test pattern.
// Video outputs are registered and only change on the clk_25 edge where pclk falls (the slot edge).
module ov_camera_emulator #(
    parameter int H_ACTIVE      = 160,
    parameter int V_ACTIVE      = 120,
    parameter int H_BLANK       = 64,
    parameter int V_SYNC_LINES  = 3,
    parameter int V_BACK_LINES  = 17,
    parameter int V_FRONT_LINES = 10
) (
    input  logic        clk_25,
    input  logic        reset_n,
    input  logic        enable,
    input  logic [1:0]  pattern_sel,
    input  logic [15:0] solid_color,
    output logic        pclk,
    output logic [7:0]  data_out,
    output logic        h_ref,
    output logic        v_sync,
    output logic        frame_done,
    output logic [7:0]  frame_count
);

    localparam int LINE_SLOTS = 2 * H_ACTIVE + H_BLANK;
    localparam int SW         = $clog2(LINE_SLOTS);
    localparam int LW         = 10;
    localparam int BAR_W      = H_ACTIVE / 8;

    localparam logic [SW-1:0] SLOT_LAST = SW'(LINE_SLOTS - 1);
    localparam logic [SW-1:0] ACT_SLOTS = SW'(2 * H_ACTIVE);
    localparam logic [7:0]    BAR_LAST  = 8'(BAR_W - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_VSYNC,
        S_VBACK,
        S_ACTIVE,
        S_VFRONT
    } state_t;

    state_t          r_state;
    logic            r_pclk;
    logic [SW-1:0]   r_slot;
    logic [LW-1:0]   r_line;
    logic [2:0]      r_bar;
    logic [7:0]      r_bar_px;
    logic [1:0]      r_pat_sel;
    logic [15:0]     r_solid;
    logic [7:0]      r_data;
    logic            r_href;
    logic            r_vsync;
    logic            r_frame_done;
    logic [7:0]      r_frame_cnt;

    state_t          w_n_state;
    logic [SW-1:0]   w_n_slot;
    logic [LW-1:0]   w_n_line;
    logic [2:0]      w_n_bar;
    logic [7:0]      w_n_bar_px;
    logic            w_latch;
    logic [LW-1:0]   w_last_line;
    logic            w_slot_edge;
    logic            w_line_end;
    logic            w_state_end;
    logic            w_frame_end;
    logic [7:2]      w_x;
    logic [6:2]      w_y;
    logic [15:0]     w_bar_pix;
    logic [15:0]     w_pix;
    logic            w_n_href;
    logic            w_n_vsync;
    logic [7:0]      w_n_data;

    assign w_slot_edge = r_pclk;
    assign w_line_end  = (r_slot == SLOT_LAST);
    assign w_state_end = w_line_end && (r_line == w_last_line);
    // With no front porch the frame ends on the last active line.
    assign w_frame_end = w_state_end &&
                         ((r_state == S_VFRONT) || ((r_state == S_ACTIVE) && (V_FRONT_LINES == 0)));

    always_comb begin
        w_last_line = '0;
        case (r_state)
            S_VSYNC:  w_last_line = LW'(V_SYNC_LINES - 1);
            S_VBACK:  w_last_line = LW'(V_BACK_LINES - 1);
            S_ACTIVE: w_last_line = LW'(V_ACTIVE - 1);
            S_VFRONT: w_last_line = LW'(V_FRONT_LINES - 1);
            default:  ;
        endcase
    end

    always_comb begin
        w_n_state = r_state;
        w_n_slot  = r_slot;
        w_n_line  = r_line;
        w_latch   = 1'b0;
        if (r_state == S_IDLE) begin
            w_n_slot = '0;
            w_n_line = '0;
            if (enable) begin
                w_n_state = S_VSYNC;
                w_latch   = 1'b1;
            end
        end else begin
            w_n_slot = w_line_end ? '0 : r_slot + 1'b1;
            if (w_line_end) begin
                w_n_line = w_state_end ? '0 : r_line + 1'b1;
            end
            if (w_frame_end) begin
                w_n_state = enable ? S_VSYNC : S_IDLE;
                w_latch   = enable;
            end else if (w_state_end) begin
                case (r_state)
                    S_VSYNC:  w_n_state = (V_BACK_LINES > 0) ? S_VBACK : S_ACTIVE;
                    S_VBACK:  w_n_state = S_ACTIVE;
                    S_ACTIVE: w_n_state = S_VFRONT;
                    default:  w_n_state = S_IDLE;
                endcase
            end
        end
    end

    // Bar index steps when the pixel-within-bar counter wraps, avoiding a divider on x.
    always_comb begin
        w_n_bar    = r_bar;
        w_n_bar_px = r_bar_px;
        if (w_n_slot == '0) begin
            w_n_bar    = '0;
            w_n_bar_px = '0;
        end else if (!w_n_slot[0]) begin
            if (r_bar_px == BAR_LAST) begin
                w_n_bar_px = '0;
                w_n_bar    = r_bar + 1'b1;
            end else begin
                w_n_bar_px = r_bar_px + 1'b1;
            end
        end
    end

    assign w_x = 6'(w_n_slot >> 3);
    assign w_y = w_n_line[6:2];

    always_comb begin
        w_bar_pix = 16'h0000;
        case (w_n_bar)
            3'd0:    w_bar_pix = 16'hFFFF;
            3'd1:    w_bar_pix = 16'hFFE0;
            3'd2:    w_bar_pix = 16'h07FF;
            3'd3:    w_bar_pix = 16'h07E0;
            3'd4:    w_bar_pix = 16'hF81F;
            3'd5:    w_bar_pix = 16'hF800;
            3'd6:    w_bar_pix = 16'h001F;
            default: w_bar_pix = 16'h0000;
        endcase
    end

    always_comb begin
        w_pix = 16'h0000;
        case (r_pat_sel)
            2'd0:    w_pix = r_solid;
            2'd1:    w_pix = w_bar_pix;
            2'd2:    w_pix = {w_x[7:3], w_x[7:2], w_y[6:2]};
            default: w_pix = (w_x[3] ^ w_y[3]) ? 16'hFFFF : 16'h0000;
        endcase
    end

    assign w_n_href  = (w_n_state == S_ACTIVE) && (w_n_slot < ACT_SLOTS);
    assign w_n_vsync = (w_n_state == S_VSYNC);
    assign w_n_data  = !w_n_href ? 8'h00 : (w_n_slot[0] ? w_pix[7:0] : w_pix[15:8]);

    always_ff @(posedge clk_25 or negedge reset_n) begin
        if (!reset_n) begin
            r_pclk       <= 1'b0;
            r_state      <= S_IDLE;
            r_slot       <= '0;
            r_line       <= '0;
            r_bar        <= '0;
            r_bar_px     <= '0;
            r_pat_sel    <= '0;
            r_solid      <= '0;
            r_data       <= '0;
            r_href       <= 1'b0;
            r_vsync      <= 1'b0;
            r_frame_done <= 1'b0;
            r_frame_cnt  <= '0;
        end else begin
            r_pclk       <= ~r_pclk;
            // Pulse lands in the second half of the final slot, while pclk is high.
            r_frame_done <= !r_pclk && w_frame_end;
            if (!r_pclk && w_frame_end) begin
                r_frame_cnt <= r_frame_cnt + 8'd1;
            end
            if (w_slot_edge) begin
                r_state  <= w_n_state;
                r_slot   <= w_n_slot;
                r_line   <= w_n_line;
                r_bar    <= w_n_bar;
                r_bar_px <= w_n_bar_px;
                r_data   <= w_n_data;
                r_href   <= w_n_href;
                r_vsync  <= w_n_vsync;
                if (w_latch) begin
                    r_pat_sel <= pattern_sel;
                    r_solid   <= solid_color;
                end
            end
        end
    end

    assign pclk        = r_pclk;
    assign data_out    = r_data;
    assign h_ref       = r_href;
    assign v_sync      = r_vsync;
    assign frame_done  = r_frame_done;
    assign frame_count = r_frame_cnt;

endmodule
